// File: rtl/xcom_pkg.sv
// Shared XCOM link definitions: receiver FSM states, header geometry,
// broadcast id, opcode encodings and the payload-length decode.
package xcom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } rx_state_t;

    localparam int         XCOM_HDR_W    = 8;
    localparam logic [3:0] XCOM_BCAST_ID = 4'd0;

    // Opcodes shared with the transmitter; op[2:1] selects the payload length.
    localparam logic [3:0] XCOM_OP_PING  = 4'h1;
    localparam logic [3:0] XCOM_OP_WR8   = 4'h2;
    localparam logic [3:0] XCOM_OP_WR16  = 4'h4;
    localparam logic [3:0] XCOM_OP_WR32  = 4'h6;

    // Payload length in bits for a given opcode.
    function automatic logic [5:0] xcom_len(input logic [3:0] op);
        logic [5:0] len;
        case (op[2:1])
            2'b00:   len = 6'd0;
            2'b01:   len = 6'd8;
            2'b10:   len = 6'd16;
            default: len = 6'd32;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/xcom_link_rx_sync.sv
// Synchronizer for the asynchronous XCOM ck/dt pins plus a toggle detector:
// every change of the synchronized ck (rise or fall) marks one bit.
module xcom_link_rx_sync #(
    parameter int SYNC_FF = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ck,
    input  logic i_dt,
    output logic o_edge,
    output logic o_dt
);

    logic [SYNC_FF-1:0] r_ck_sync;
    logic [SYNC_FF-1:0] r_dt_sync;
    logic               r_ck_d1;

    // Shift both pins through equal-depth chains so dt stays aligned to ck.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ck_sync <= '0;
            r_dt_sync <= '0;
            r_ck_d1   <= 1'b0;
        end else begin
            r_ck_sync <= {r_ck_sync[SYNC_FF-2:0], i_ck};
            r_dt_sync <= {r_dt_sync[SYNC_FF-2:0], i_dt};
            r_ck_d1   <= r_ck_sync[SYNC_FF-1];
        end
    end

    assign o_edge = r_ck_sync[SYNC_FF-1] ^ r_ck_d1;
    assign o_dt   = r_dt_sync[SYNC_FF-1];

endmodule

// File: rtl/xcom_link_rx.sv
// XCOM link receiver: recovers header + 0/8/16/32-bit payload frames from
// the remote ck/dt pair, filters by local id (or broadcast id 0) and emits a
// one-cycle accept strobe, or an error strobe when ck stalls mid-frame.
// Optional build macro XCOM_LINK_RX_STATS_EN adds saturating 16-bit counters
// of accepted frames and timeouts.
module xcom_link_rx
    import xcom_pkg::*;
#(
    parameter int TOUT_CYC = 64,
    parameter int SYNC_FF  = 2
) (
    input  logic        x_clk,
    input  logic        x_rst,
    input  logic        xcom_ck_i,
    input  logic        xcom_dt_i,
    input  logic [3:0]  my_id_i,
    output logic        rx_vld_o,
    output logic [3:0]  rx_op_o,
    output logic [3:0]  rx_id_o,
    output logic [31:0] rx_dt_o,
    output logic        rx_err_o,
`ifdef XCOM_LINK_RX_STATS_EN
    output logic [15:0] rx_frm_cnt_o,
    output logic [15:0] rx_err_cnt_o,
`endif
    output logic        rx_busy_o
);

    localparam logic [9:0] TOUT_LIM = 10'(TOUT_CYC);

    logic       w_edge;
    logic       w_dt;
    logic [7:0] w_hdr_next;
    logic [5:0] w_frame_bits;
    logic       w_id_hit;

    rx_state_t   r_state;
    logic [7:0]  r_hdr;
    logic [31:0] r_data;
    logic [5:0]  r_bitcnt;
    logic [9:0]  r_tout;

    xcom_link_rx_sync #(
        .SYNC_FF (SYNC_FF)
    ) u_sync (
        .i_clk  (x_clk),
        .i_rst  (x_rst),
        .i_ck   (xcom_ck_i),
        .i_dt   (xcom_dt_i),
        .o_edge (w_edge),
        .o_dt   (w_dt)
    );

    assign w_hdr_next   = {r_hdr[6:0], w_dt};
    assign w_frame_bits = 6'(XCOM_HDR_W) + xcom_len(r_hdr[7:4]);
    assign w_id_hit     = (r_hdr[3:0] == my_id_i) || (r_hdr[3:0] == XCOM_BCAST_ID);

    // Frame FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge x_clk) begin
        if (x_rst) begin
            r_state   <= IDLE;
            r_hdr     <= '0;
            r_data    <= '0;
            r_bitcnt  <= '0;
            r_tout    <= '0;
            rx_vld_o  <= 1'b0;
            rx_op_o   <= '0;
            rx_id_o   <= '0;
            rx_dt_o   <= '0;
            rx_err_o  <= 1'b0;
            rx_busy_o <= 1'b0;
`ifdef XCOM_LINK_RX_STATS_EN
            rx_frm_cnt_o <= '0;
            rx_err_cnt_o <= '0;
`endif
        end else begin
            rx_vld_o <= 1'b0;
            rx_err_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_state   <= HDR;
                        r_hdr     <= {7'd0, w_dt};
                        r_bitcnt  <= 6'd1;
                        r_tout    <= '0;
                        rx_busy_o <= 1'b1;
                    end
                end
                HDR: begin
                    if (w_edge) begin
                        r_hdr    <= w_hdr_next;
                        r_bitcnt <= r_bitcnt + 6'd1;
                        r_tout   <= '0;
                        if (r_bitcnt == 6'(XCOM_HDR_W - 1)) begin
                            r_data  <= '0;
                            r_state <= (xcom_len(w_hdr_next[7:4]) == 6'd0) ? DONE : DATA;
                        end
                    end else if (r_tout + 10'd1 >= TOUT_LIM) begin
                        r_state   <= IDLE;
                        rx_err_o  <= 1'b1;
                        rx_busy_o <= 1'b0;
`ifdef XCOM_LINK_RX_STATS_EN
                        if (rx_err_cnt_o != 16'hFFFF) rx_err_cnt_o <= rx_err_cnt_o + 16'd1;
`endif
                    end else begin
                        r_tout <= r_tout + 10'd1;
                    end
                end
                DATA: begin
                    if (w_edge) begin
                        r_data   <= {r_data[30:0], w_dt};
                        r_bitcnt <= r_bitcnt + 6'd1;
                        r_tout   <= '0;
                        if (r_bitcnt == w_frame_bits - 6'd1) r_state <= DONE;
                    end else if (r_tout + 10'd1 >= TOUT_LIM) begin
                        r_state   <= IDLE;
                        rx_err_o  <= 1'b1;
                        rx_busy_o <= 1'b0;
`ifdef XCOM_LINK_RX_STATS_EN
                        if (rx_err_cnt_o != 16'hFFFF) rx_err_cnt_o <= rx_err_cnt_o + 16'd1;
`endif
                    end else begin
                        r_tout <= r_tout + 10'd1;
                    end
                end
                default: begin
                    // DONE: publish matching frames, silently drop the rest.
                    if (w_id_hit) begin
                        rx_vld_o <= 1'b1;
                        rx_op_o  <= r_hdr[7:4];
                        rx_id_o  <= r_hdr[3:0];
                        rx_dt_o  <= r_data;
`ifdef XCOM_LINK_RX_STATS_EN
                        if (rx_frm_cnt_o != 16'hFFFF) rx_frm_cnt_o <= rx_frm_cnt_o + 16'd1;
`endif
                    end
                    // An edge here is already the first header bit of the next frame.
                    if (w_edge) begin
                        r_state   <= HDR;
                        r_hdr     <= {7'd0, w_dt};
                        r_bitcnt  <= 6'd1;
                        r_tout    <= '0;
                        rx_busy_o <= 1'b1;
                    end else begin
                        r_state   <= IDLE;
                        r_bitcnt  <= '0;
                        rx_busy_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xcom_link_rx.sv
// Directed bench for xcom_link_rx: drives the link pins bit by bit (one ck
// toggle every 4 x_clk, dt set 2 cycles ahead of each toggle) and checks
// frame strobes, payloads, filtering, timeout, back-to-back and reset.
module tb_xcom_link_rx;

    localparam int TOUT = 64;

    logic        x_clk = 1'b0;
    logic        x_rst;
    logic        ck;
    logic        dt;
    logic [3:0]  my_id;
    logic        rx_vld_o;
    logic [3:0]  rx_op_o;
    logic [3:0]  rx_id_o;
    logic [31:0] rx_dt_o;
    logic        rx_err_o;
    logic        rx_busy_o;
`ifdef XCOM_LINK_RX_STATS_EN
    logic [15:0] rx_frm_cnt_o;
    logic [15:0] rx_err_cnt_o;
`endif

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int vld_cyc = 0;
    int tog_cyc = 0;
    logic [31:0] cap_dt [0:15];
    logic [3:0]  cap_op [0:15];

    xcom_link_rx #(
        .TOUT_CYC (TOUT),
        .SYNC_FF  (2)
    ) dut (
        .x_clk        (x_clk),
        .x_rst        (x_rst),
        .xcom_ck_i    (ck),
        .xcom_dt_i    (dt),
        .my_id_i      (my_id),
        .rx_vld_o     (rx_vld_o),
        .rx_op_o      (rx_op_o),
        .rx_id_o      (rx_id_o),
        .rx_dt_o      (rx_dt_o),
        .rx_err_o     (rx_err_o),
`ifdef XCOM_LINK_RX_STATS_EN
        .rx_frm_cnt_o (rx_frm_cnt_o),
        .rx_err_cnt_o (rx_err_cnt_o),
`endif
        .rx_busy_o    (rx_busy_o)
    );

    always #5 x_clk = ~x_clk;

    always @(posedge x_clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge x_clk) begin
        if (rx_vld_o === 1'b1) begin
            if (vld_cnt < 16) begin
                cap_dt[vld_cnt] = rx_dt_o;
                cap_op[vld_cnt] = rx_op_o;
            end
            vld_cnt = vld_cnt + 1;
            vld_cyc = cyc;
        end
        if (rx_err_o === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        dt = b;
        repeat (2) @(negedge x_clk);
        ck = ~ck;
        tog_cyc = cyc;
        repeat (2) @(negedge x_clk);
    endtask

    // Sends header then payload MSB first, stopping after 'limit' bits.
    task automatic send_frame(input logic [3:0] op, input logic [3:0] id,
                              input logic [31:0] pl, input int limit);
        logic [7:0] hdr;
        int len;
        int sent;
        hdr = {op, id};
        case (op[2:1])
            2'b00:   len = 0;
            2'b01:   len = 8;
            2'b10:   len = 16;
            default: len = 32;
        endcase
        sent = 0;
        for (int i = 7; i >= 0; i--) begin
            if (sent < limit) begin
                send_bit(hdr[i]);
                sent++;
            end
        end
        for (int i = len - 1; i >= 0; i--) begin
            if (sent < limit) begin
                send_bit(pl[i]);
                sent++;
            end
        end
    endtask

    task automatic gap();
        repeat (8) @(negedge x_clk);
        #2;
    endtask

    initial begin
        x_rst = 1'b1;
        ck    = 1'b0;
        dt    = 1'b0;
        my_id = 4'd3;
        repeat (4) @(negedge x_clk);
        #2;
        chk("rst_vld",  {31'd0, rx_vld_o},  32'd0);
        chk("rst_err",  {31'd0, rx_err_o},  32'd0);
        chk("rst_busy", {31'd0, rx_busy_o}, 32'd0);
        chk("rst_op",   {28'd0, rx_op_o},   32'd0);
        chk("rst_dt",   rx_dt_o,            32'd0);
        @(negedge x_clk);
        x_rst = 1'b0;
        repeat (2) @(negedge x_clk);

        // 1: header-only frame addressed to us, plus strobe latency
        send_frame(4'h1, 4'd3, 32'd0, 40);
        repeat (4) @(negedge x_clk);
        #2;
        chk("t1_cnt", vld_cnt, 1);
        chk("t1_lat", vld_cyc - tog_cyc, 4);
        chk("t1_op",  {28'd0, cap_op[0]}, 32'h1);
        chk("t1_id",  {28'd0, rx_id_o},   32'h3);
        chk("t1_dt",  cap_dt[0], 32'h0);
        chk("t1_vld_low", {31'd0, rx_vld_o}, 32'd0);
        gap();

        // 2: 8-bit and 32-bit payloads
        send_frame(4'h2, 4'd3, 32'h0000_00A5, 40);
        gap();
        chk("t2_cnt8", vld_cnt, 2);
        chk("t2_dt8",  cap_dt[1], 32'h0000_00A5);
        send_frame(4'h6, 4'd3, 32'hDEAD_BEEF, 40);
        gap();
        chk("t2_cnt32", vld_cnt, 3);
        chk("t2_dt32",  rx_dt_o, 32'hDEAD_BEEF);
        chk("t2_op32",  {28'd0, rx_op_o}, 32'h6);

        // 3: foreign id dropped with outputs held; broadcast accepted
        send_frame(4'h4, 4'd5, 32'h0000_7777, 40);
        gap();
        chk("t3_drop_cnt", vld_cnt, 3);
        chk("t3_hold_dt",  rx_dt_o, 32'hDEAD_BEEF);
        chk("t3_hold_op",  {28'd0, rx_op_o}, 32'h6);
        chk("t3_drop_err", err_cnt, 0);
        send_frame(4'h4, 4'd0, 32'h0000_1234, 40);
        gap();
        chk("t3_bc_cnt", vld_cnt, 4);
        chk("t3_bc_dt",  rx_dt_o, 32'h0000_1234);
        chk("t3_bc_id",  {28'd0, rx_id_o}, 32'h0);

        // 4: ck stalls after 12 of 24 bits
        send_frame(4'h4, 4'd3, 32'h0000_ABCD, 12);
        #2;
        chk("t4_busy_mid", {31'd0, rx_busy_o}, 32'd1);
        repeat (TOUT + 4) @(negedge x_clk);
        #2;
        chk("t4_err",  err_cnt, 1);
        chk("t4_busy", {31'd0, rx_busy_o}, 32'd0);
        chk("t4_novld", vld_cnt, 4);
        send_frame(4'h2, 4'd3, 32'h0000_005A, 40);
        gap();
        chk("t4_next_cnt", vld_cnt, 5);
        chk("t4_next_dt",  rx_dt_o, 32'h0000_005A);

        // 5: two frames with no gap between them
        send_frame(4'h2, 4'd3, 32'h0000_0011, 40);
        send_frame(4'h4, 4'd3, 32'h0000_BEEF, 40);
        gap();
        chk("t5_cnt", vld_cnt, 7);
        chk("t5_dt_a", cap_dt[5], 32'h0000_0011);
        chk("t5_dt_b", cap_dt[6], 32'h0000_BEEF);
        chk("t5_err", err_cnt, 1);

        // 6: reset mid-DATA, then a fresh frame
        send_frame(4'h2, 4'd3, 32'h0000_00FF, 12);
        x_rst = 1'b1;
        repeat (2) @(negedge x_clk);
        x_rst = 1'b0;
        repeat (2) @(negedge x_clk);
        #2;
        chk("t6_novld", vld_cnt, 7);
        chk("t6_noerr", err_cnt, 1);
        chk("t6_busy",  {31'd0, rx_busy_o}, 32'd0);
        chk("t6_rst_dt", rx_dt_o, 32'h0);
        send_frame(4'h2, 4'd3, 32'h0000_003C, 40);
        gap();
        chk("t6_cnt", vld_cnt, 8);
        chk("t6_dt",  rx_dt_o, 32'h0000_003C);
`ifdef XCOM_LINK_RX_STATS_EN
        chk("t6_frm_cnt", {16'd0, rx_frm_cnt_o}, 32'd1);
        chk("t6_err_cnt", {16'd0, rx_err_cnt_o}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
